// File: rtl/bram_wr_ctrl.sv
// BRAM write controller: registers one masked-write request, writes it, optionally
// reads it back for verification, then closes a 4-phase level handshake upstream.
module bram_wr_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int VERIFY = 1,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_bram_trig,
  input  logic [ADDR_W-1:0] i_wr_bram_addr,
  input  logic [DATA_W-1:0] i_wr_bram_data,
  output logic              o_wr_bram_ack,
  output logic              o_bram_en,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [DATA_W-1:0] o_bram_din,
  input  logic [DATA_W-1:0] i_bram_dout,
  output logic              o_busy,
  output logic              o_verify_err,
  output logic [CNT_W-1:0]  o_wr_count
);

  typedef enum logic [2:0] {IDLE, WRITE, RDBACK, WAIT, ACK} state_t;

  localparam logic [1:0]       WAIT_LAST = 2'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state;
  logic [1:0] wait_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      o_wr_bram_ack <= 1'b0;
      o_bram_en     <= 1'b0;
      o_bram_we     <= 1'b0;
      o_bram_addr   <= '0;
      o_bram_din    <= '0;
      o_busy        <= 1'b0;
      o_verify_err  <= 1'b0;
      o_wr_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_bram_en     <= 1'b0;
          o_bram_we     <= 1'b0;
          o_wr_bram_ack <= 1'b0;
          if (i_wr_bram_trig) begin
            o_bram_addr <= i_wr_bram_addr;
            o_bram_din  <= i_wr_bram_data;
            o_bram_en   <= 1'b1;
            o_bram_we   <= 1'b1;
            o_busy      <= 1'b1;
            state       <= WRITE;
          end
        end
        WRITE: begin
          o_bram_we <= 1'b0;
          if (VERIFY != 0) begin
            o_bram_en <= 1'b1;
            state     <= RDBACK;
          end else begin
            o_bram_en <= 1'b0;
            state     <= ACK;
          end
        end
        RDBACK: begin
          o_bram_en <= 1'b0;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // Read data lands on the last wait cycle; o_bram_din still holds the written word.
          if (wait_cnt == WAIT_LAST) begin
            if (i_bram_dout != o_bram_din) o_verify_err <= 1'b1;
            state <= ACK;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ACK: begin
          // First ACK cycle always raises ack, so an early-dropped trig still sees one ack cycle.
          if (!o_wr_bram_ack) begin
            o_wr_bram_ack <= 1'b1;
            o_wr_count    <= sat_inc(o_wr_count);
          end else if (!i_wr_bram_trig) begin
            o_wr_bram_ack <= 1'b0;
            o_busy        <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_wr_ctrl.sv
// Bench for bram_wr_ctrl: two configurations driven by directed and random requests,
// checked every cycle against a transaction-timeline model plus literal expectations.
module tb_bram_wr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_s   [2];
  logic        trig_s  [2];
  logic [12:0] addr_s  [2];
  logic [31:0] data_s  [2];
  logic        corrupt [2];

  logic        ack_o   [2];
  logic        en_o    [2];
  logic        we_o    [2];
  logic [12:0] baddr_o [2];
  logic [31:0] din_o   [2];
  logic        busy_o  [2];
  logic        err_o   [2];
  logic [15:0] cnt_o   [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Instance 0: VERIFY=1, RD_LAT=2, CNT_W=4.  Instance 1: VERIFY=0, RD_LAT=1, CNT_W=16.
  for (genvar g = 0; g < 2; g++) begin : gen_i
    localparam int VER  = (g == 0) ? 1 : 0;
    localparam int RDL  = (g == 0) ? 2 : 1;
    localparam int CW   = (g == 0) ? 4 : 16;
    localparam int RISE = (VER != 0) ? 3 + RDL : 2;
    localparam int CMAX = (1 << CW) - 1;

    logic [CW-1:0] cnt_w;
    logic [31:0]   dout;
    logic [31:0]   mem  [256];
    logic [31:0]   pipe [RDL];

    bram_wr_ctrl #(.ADDR_W(13), .DATA_W(32), .RD_LAT(RDL), .VERIFY(VER), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst(rst_s[g]), .i_wr_bram_trig(trig_s[g]),
      .i_wr_bram_addr(addr_s[g]), .i_wr_bram_data(data_s[g]),
      .o_wr_bram_ack(ack_o[g]), .o_bram_en(en_o[g]), .o_bram_we(we_o[g]),
      .o_bram_addr(baddr_o[g]), .o_bram_din(din_o[g]), .i_bram_dout(dout),
      .o_busy(busy_o[g]), .o_verify_err(err_o[g]), .o_wr_count(cnt_w)
    );
    assign cnt_o[g] = 16'(cnt_w);
    assign dout     = pipe[RDL-1];

    // BRAM with RD_LAT-deep read pipeline; non-read cycles push a garbage word.
    always @(posedge clk) begin
      if (en_o[g] && we_o[g]) mem[baddr_o[g][7:0]] <= din_o[g];
      if (en_o[g] && !we_o[g]) pipe[0] <= mem[baddr_o[g][7:0]] ^ {31'd0, corrupt[g]};
      else pipe[0] <= 32'hA5A5_A5A5;
      for (int j = 1; j < RDL; j++) pipe[j] <= pipe[j-1];
    end

    // Reference: each accepted request is a timeline relative to its accept edge t0.
    int k = 0, t0 = 0, r = 0, m_cnt = 0;
    logic mvalid = 1'b0, act = 1'b0, corr_t = 1'b0;
    logic m_ack, m_en, m_we, m_busy, m_err;
    logic [12:0] m_addr;
    logic [31:0] m_din;

    always @(posedge clk) begin
      k++;
      if (rst_s[g]) begin
        mvalid = 1'b1; act = 1'b0;
        m_ack = 0; m_en = 0; m_we = 0; m_busy = 0; m_err = 0; m_cnt = 0;
        m_addr = '0; m_din = '0;
      end else if (!act) begin
        m_en = 0; m_we = 0; m_ack = 0;
        if (trig_s[g]) begin
          act = 1'b1; t0 = k; corr_t = corrupt[g];
          m_addr = addr_s[g]; m_din = data_s[g];
          m_en = 1; m_we = 1; m_busy = 1;
        end
      end else begin
        r = k - t0;
        m_en = (VER != 0) && (r == 1);
        m_we = 0;
        if ((VER != 0) && (r == 2 + RDL) && corr_t) m_err = 1;
        if (r == RISE) begin
          m_ack = 1;
          if (m_cnt < CMAX) m_cnt++;
        end else if (r > RISE && !trig_s[g]) begin
          m_ack = 0; m_busy = 0; act = 1'b0;
        end
      end
    end

    always @(negedge clk) begin
      if (mvalid) begin
        chk($sformatf("i%0d ack", g),  {31'd0, ack_o[g]},  {31'd0, m_ack});
        chk($sformatf("i%0d en", g),   {31'd0, en_o[g]},   {31'd0, m_en});
        chk($sformatf("i%0d we", g),   {31'd0, we_o[g]},   {31'd0, m_we});
        chk($sformatf("i%0d addr", g), {19'd0, baddr_o[g]}, {19'd0, m_addr});
        chk($sformatf("i%0d din", g),  din_o[g], m_din);
        chk($sformatf("i%0d busy", g), {31'd0, busy_o[g]}, {31'd0, m_busy});
        chk($sformatf("i%0d verr", g), {31'd0, err_o[g]},  {31'd0, m_err});
        chk($sformatf("i%0d cnt", g),  {16'd0, cnt_o[g]},  32'(m_cnt));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int g);
    rst_s[g] = 1'b1; trig_s[g] = 1'b0;
    tick(1);
    chk("rst ack",  {31'd0, ack_o[g]},  0);
    chk("rst en",   {31'd0, en_o[g]},   0);
    chk("rst we",   {31'd0, we_o[g]},   0);
    chk("rst addr", {19'd0, baddr_o[g]}, 0);
    chk("rst din",  din_o[g], 0);
    chk("rst busy", {31'd0, busy_o[g]}, 0);
    chk("rst verr", {31'd0, err_o[g]},  0);
    chk("rst cnt",  {16'd0, cnt_o[g]},  0);
    rst_s[g] = 1'b0;
  endtask

  // pulse>0: trig held for that many cycles regardless of ack; else held until ack plus hold.
  task automatic txn(input int g, input logic [12:0] a, input logic [31:0] d,
                     input int hold, input int pulse);
    int n;
    trig_s[g] = 1'b1; addr_s[g] = a; data_s[g] = d;
    if (pulse > 0) begin
      tick(pulse);
      trig_s[g] = 1'b0;
    end else begin
      n = 0;
      while (!ack_o[g] && n < 20) begin tick(1); n++; end
      chk("ack_wait", {31'd0, ack_o[g]}, 1);
      tick(hold);
      trig_s[g] = 1'b0;
    end
    n = 0;
    while (busy_o[g] && n < 20) begin tick(1); n++; end
    chk("idle_wait", {31'd0, busy_o[g]}, 0);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst_s[g] = 1'b1; trig_s[g] = 0; addr_s[g] = '0; data_s[g] = '0; corrupt[g] = 0;
    end
    tick(3);
    do_reset(0);
    do_reset(1);

    // VERIFY=0 basic write and ack timing
    trig_s[1] = 1; addr_s[1] = 13'h0A5; data_s[1] = 32'hDEADBEEF;
    tick(1);
    chk("t1 en", {31'd0, en_o[1]}, 1);
    chk("t1 we", {31'd0, we_o[1]}, 1);
    chk("t1 addr", {19'd0, baddr_o[1]}, 32'h0A5);
    chk("t1 din", din_o[1], 32'hDEADBEEF);
    tick(1);
    chk("t1 ack e1", {31'd0, ack_o[1]}, 0);
    chk("t1 en e1", {31'd0, en_o[1]}, 0);
    tick(1);
    chk("t1 ack e2", {31'd0, ack_o[1]}, 1);
    chk("t1 cnt", {16'd0, cnt_o[1]}, 1);
    tick(1);
    trig_s[1] = 0;
    tick(1);
    chk("t1 ack fall", {31'd0, ack_o[1]}, 0);

    // VERIFY=1, RD_LAT=2 sequence
    trig_s[0] = 1; addr_s[0] = 13'h123; data_s[0] = 32'h0BADF00D;
    tick(1);
    chk("t2 write", {30'd0, en_o[0], we_o[0]}, 3);
    tick(1);
    chk("t2 rdback", {30'd0, en_o[0], we_o[0]}, 2);
    chk("t2 rd addr", {19'd0, baddr_o[0]}, 32'h123);
    tick(1);
    chk("t2 wait1", {30'd0, en_o[0], ack_o[0]}, 0);
    tick(2);
    chk("t2 ack e4", {31'd0, ack_o[0]}, 0);
    tick(1);
    chk("t2 ack e5", {31'd0, ack_o[0]}, 1);
    chk("t2 verr", {31'd0, err_o[0]}, 0);
    trig_s[0] = 0;
    tick(1);

    // Corrupted readback sets sticky verify_err
    corrupt[0] = 1;
    txn(0, 13'h007, 32'h00000001, 0, 0);
    corrupt[0] = 0;
    chk("t3 verr set", {31'd0, err_o[0]}, 1);
    for (int i = 0; i < 3; i++) txn(0, 13'(i + 8), 32'h100 + i, 1, 0);
    chk("t3 verr sticky", {31'd0, err_o[0]}, 1);
    do_reset(0);

    // Reset while in RDBACK
    trig_s[0] = 1; addr_s[0] = 13'h044; data_s[0] = 32'h44444444;
    tick(2);
    chk("t6 in rdback", {30'd0, en_o[0], we_o[0]}, 2);
    do_reset(0);
    txn(0, 13'h045, 32'h55555555, 0, 0);
    chk("t6 clean cnt", {16'd0, cnt_o[0]}, 1);

    // Single-cycle trig pulse
    txn(0, 13'h046, 32'h66666666, 0, 1);
    chk("t4 cnt", {16'd0, cnt_o[0]}, 2);

    // Counter saturation at CNT_W=4
    do_reset(0);
    for (int i = 0; i < 17; i++) txn(0, 13'(i), $urandom, 0, 0);
    chk("t7 sat", {16'd0, cnt_o[0]}, 15);

    // Held trig with mid-transaction input changes
    do_reset(1);
    trig_s[1] = 1; addr_s[1] = 13'h111; data_s[1] = 32'h11111111;
    tick(1);
    addr_s[1] = 13'h1FFF; data_s[1] = 32'h0;
    tick(11);
    chk("t5 addr", {19'd0, baddr_o[1]}, 32'h111);
    chk("t5 din", din_o[1], 32'h11111111);
    chk("t5 cnt", {16'd0, cnt_o[1]}, 1);
    chk("t5 ack held", {31'd0, ack_o[1]}, 1);
    trig_s[1] = 0;
    tick(2);

    // Random traffic
    for (int i = 0; i < 160; i++) begin
      int g;
      g = i % 2;
      corrupt[g] = (g == 0) && ($urandom_range(0, 3) == 0);
      txn(g, 13'($urandom), $urandom, $urandom_range(0, 4),
          ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0);
      corrupt[g] = 0;
      tick($urandom_range(0, 2));
      if ($urandom_range(0, 40) == 0) do_reset(g);
    end

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/bram_wr_ctrl.md
Name: bram_wr_ctrl

Overview:
- Drives the single-port BRAM write for the connected-domain filter. It consumes the masked-write request (trig/addr/data) from the mask-merge stage and returns the ack that stage reports as done.
- Registers each request and performs the BRAM write, with an optional read-back verify.
- Closes a 4-phase level handshake with upstream.
- Also counts completed writes and flags verify mismatches.

Parameters:
- ADDR_W, 13: BRAM word-address width.
- DATA_W, 32: BRAM data width.
- RD_LAT, 1: BRAM read latency in cycles, valid range 1..3.
- VERIFY, 1: 1 enables read-back compare; 0 skips it.
- CNT_W, 16: write-counter width.

Ports:
- i_clk  in  1  single clock; all logic is on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_wr_bram_trig  in  1  request level from upstream, held until ack is seen.
- i_wr_bram_addr  in  ADDR_W  request word address.
- i_wr_bram_data  in  DATA_W  request write data.
- o_wr_bram_ack  out  1  registered ack, held while the request is held.
- o_bram_en  out  1  BRAM port enable.
- o_bram_we  out  1  BRAM write enable.
- o_bram_addr  out  ADDR_W  BRAM address.
- o_bram_din  out  DATA_W  BRAM write data.
- i_bram_dout  in  DATA_W  BRAM read data, valid RD_LAT cycles after a read-enable cycle.
- o_busy  out  1  high whenever state is not IDLE.
- o_verify_err  out  1  sticky read-back mismatch flag.
- o_wr_count  out  CNT_W  completed-write count, saturating.

Behaviour:
- Reset (edge with i_rst=1):
  - state=IDLE.
  - All outputs are 0: ack, en, we, addr, din, busy, verify_err, wr_count.
  - Reset overrides every state, including mid-write. A write already issued on a prior cycle is not undone.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, WRITE, RDBACK, WAIT, ACK.
- IDLE:
  - en=0, we=0; addr/din hold their last values.
  - On an edge with trig=1: capture addr/data into o_bram_addr/o_bram_din and go to WRITE.
- WRITE (exactly 1 cycle):
  - en=1, we=1.
  - Next state is RDBACK if VERIFY=1, else ACK.
- RDBACK (1 cycle): en=1, we=0, same address.
- WAIT (RD_LAT cycles, counted by an internal counter):
  - en=0, we=0.
  - In the last WAIT cycle, compare i_bram_dout with o_bram_din. On mismatch, set o_verify_err; it stays set until reset.
  - Then go to ACK.
- ACK:
  - ack=1.
  - On entry, o_wr_count increments by 1, saturating at all-ones.
  - On an edge with trig=0: go to IDLE, ack falls.
  - While trig=1: stay in ACK.
- Latency from the first edge sampling trig=1 (edge 0):
  - WRITE during cycle 0→1.
  - ack high after edge 2 when VERIFY=0.
  - ack high after edge 3+RD_LAT when VERIFY=1.
- Request inputs are captured only in IDLE. Changes to addr/data during a transaction are ignored.
- If trig drops before ACK, the write and verify still complete. ack is then high for exactly one cycle, then IDLE.
- A held trig cannot cause a second write: ACK is left only once trig is low, and a new request needs trig=1 sampled in IDLE.
- Back-to-back requests: minimum spacing is one IDLE cycle between transactions.

Test Plan:
- VERIFY=0; trig=1, addr=0x0A5, data=0xDEADBEEF held until ack → one cycle with en=we=1, addr=0x0A5, din=0xDEADBEEF; ack high 2 cycles after trig sampled; count=1; ack falls 1 cycle after trig drops.
- VERIFY=1, RD_LAT=2, BRAM model returns the written word → sequence WRITE, RDBACK, WAIT×2, ACK; verify_err=0; ack asserted 5 cycles after trig sampled.
- VERIFY=1, BRAM model corrupts bit 0 on readback of 0x00000001 → verify_err=1 and stays 1 across 3 further good writes until i_rst.
- trig pulsed high for 1 cycle only → exactly one write, ack high for exactly one cycle, count increments by 1, no second write.
- trig held 10 cycles after ack, with addr/data changed mid-transaction → single write with the originally captured values; count=1.
- Assert i_rst in the RDBACK state → next cycle all outputs 0, busy=0, count=0; a new trig then starts a clean transaction.
- CNT_W=4; run 17 writes → count saturates at 15.
